// File: rtl/counter_pkg.sv
// Shared types for the counter command sequencer: default width, command opcodes
// and controller states.
package counter_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_GOTO = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT
    } ctrl_state_e;

endpackage

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for an external loadable up/down counter: turns LOAD/UP/DOWN/GOTO
// commands into ld_en/en/updwn pulses and reports the settled count on completion.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_arg,
    input  logic         abort,
    output logic         ld_en,
    output logic         updwn,
    output logic         en,
    output logic [W-1:0] datain,
    input  logic [W-1:0] dataout,
    output logic         done,
    output logic         aborted,
    output logic [W-1:0] result,
    output logic         busy
);

    ctrl_state_e  state, state_d;
    logic [W-1:0] remaining, remaining_d;
    logic         abort_pend, abort_pend_d;
    logic         ld_en_d, en_d, updwn_d, done_d, aborted_d, busy_d, cmd_ready_d;
    logic [W-1:0] datain_d, result_d;
    cmd_op_e      op;

    assign op = cmd_op_e'(cmd_op);

    always_comb begin
        // NOTE: every *_d gets a default before the case so no path leaves a latch.
        state_d      = state;
        remaining_d  = remaining;
        abort_pend_d = abort_pend;
        ld_en_d      = 1'b0;
        en_d         = 1'b0;
        updwn_d      = updwn;
        datain_d     = datain;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        result_d     = result;

        unique case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    abort_pend_d = 1'b0;
                    unique case (op)
                        OP_LOAD: begin
                            ld_en_d  = 1'b1;
                            datain_d = cmd_arg;
                            state_d  = ST_LOAD;
                        end
                        OP_UP, OP_DOWN: begin
                            updwn_d     = (op == OP_UP);
                            remaining_d = cmd_arg;
                            en_d        = (cmd_arg != '0);
                            state_d     = (cmd_arg != '0) ? ST_RUN : ST_WAIT;
                        end
                        OP_GOTO: begin
                            // Direction chosen from the unsigned distance, so GOTO never wraps.
                            updwn_d     = (cmd_arg > dataout);
                            remaining_d = (cmd_arg > dataout) ? cmd_arg - dataout
                                                              : dataout - cmd_arg;
                            en_d        = (cmd_arg != dataout);
                            state_d     = (cmd_arg != dataout) ? ST_RUN : ST_WAIT;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                // The step for this cycle is already registered; the last step wins over abort.
                if (remaining == W'(1)) begin
                    state_d = ST_WAIT;
                end else if (abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = ST_WAIT;
                end else begin
                    remaining_d = remaining - W'(1);
                    en_d        = 1'b1;
                end
            end
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: begin
                result_d  = dataout;
                done_d    = 1'b1;
                aborted_d = abort_pend;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            abort_pend <= 1'b0;
            ld_en      <= 1'b0;
            en         <= 1'b0;
            updwn      <= 1'b0;
            datain     <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            result     <= '0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            state      <= state_d;
            remaining  <= remaining_d;
            abort_pend <= abort_pend_d;
            ld_en      <= ld_en_d;
            en         <= en_d;
            updwn      <= updwn_d;
            datain     <= datain_d;
            done       <= done_d;
            aborted    <= aborted_d;
            result     <= result_d;
            busy       <= busy_d;
            cmd_ready  <= cmd_ready_d;
        end
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Command-driven sequencer for the 8-bit loadable up/down counter.
- Accepts LOAD / UP-by-N / DOWN-by-N / GOTO-target commands over a valid/ready handshake.
- Drives the counter's ld_en/updwn/en/datain, observes dataout, and reports completion with the final count.
- Sits between the test/stimulus layer or a host register block and the counter instance.

Parameters:
- W, 8, data width of the counter and command argument.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset: asynchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  0=LOAD, 1=UP, 2=DOWN, 3=GOTO.
- cmd_arg  input  W  load value, step count, or target value.
- abort  input  1  terminate current RUN early.
- ld_en  output  1  counter load enable.
- updwn  output  1  counter direction, 1=up.
- en  output  1  counter count enable.
- datain  output  W  counter load value.
- dataout  input  W  counter current value.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  qualifies done: command was cut short.
- result  output  W  dataout captured at completion, held until next completion.
- busy  output  1  command in progress (state != IDLE).

Behaviour:
- Counter contract: on each posedge, if ld_en then load datain, else if en then ±1 modulo 2^W per updwn; dataout is registered.
- All controller outputs are registered.
- Reset: state IDLE; ld_en, en, updwn, done, aborted, busy = 0; datain and result = 0; cmd_ready = 1 after reset release.
- States: IDLE, LOAD, RUN, WAIT.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid && cmd_ready (edge E0); latch op/arg.
  - LOAD -> LOAD state; ld_en=1, datain=arg for exactly one cycle.
  - UP/DOWN with arg!=0 -> RUN; remaining=arg, updwn=(op==UP).
  - GOTO with arg!=dataout -> RUN. updwn=(arg>dataout) unsigned; remaining=|arg-dataout|. Never wraps.
  - UP/DOWN with arg==0, or GOTO with arg==dataout -> WAIT directly.
- RUN:
  - en=1 every cycle; remaining decrements per edge.
  - When the last step is issued (remaining==1), next state is WAIT and en=0.
  - Exactly `remaining` counter steps occur.
- LOAD: after one cycle -> WAIT.
- WAIT: en=ld_en=0 for one cycle so dataout settles. At its closing edge: result<=dataout, done<=1, state IDLE.
- done/aborted: done high exactly one cycle, coincident with cmd_ready=1. A new command is accepted in that same cycle. aborted is valid only with done and otherwise 0.
- Latency from accept edge E0 to done cycle:
  - UP/DOWN/GOTO with N steps: done in the cycle after edge E0+N+1.
  - LOAD: done after E0+2.
  - Zero-step commands: done after E0+1.
- Wrap-around: UP/DOWN wrap modulo 2^W (UP 10 from 250 -> 4; DOWN 3 from 1 -> 254).
- abort:
  - Sampled only in RUN; en deasserts at the next edge, then -> WAIT; done and aborted=1.
  - At most one extra step occurs, if abort coincides with a step already registered.
  - abort in IDLE/LOAD/WAIT is ignored.
  - abort in the same cycle as the last step behaves as normal completion, aborted=0.
- cmd_valid while busy: cmd_ready=0, command not consumed; cmd_op/cmd_arg must be held stable.
- Reset mid-operation: immediate return to reset values; no done; counter is left wherever it was.

Decomposition:
- Shared package counter_pkg: W default constant; cmd_op_e enum (LOAD, UP, DOWN, GOTO); ctrl_state_e enum (IDLE, LOAD, RUN, WAIT).
- Single module, no sub-module.
- Step counter and direction logic stay inline (roughly 150–250 lines RTL).

Test Plan:
- Reset, then LOAD 8'h3C -> ld_en=1, datain=3C for one cycle; done 2 cycles after accept; result=3C; busy drops with done.
- From 3C, UP 5 -> en high exactly 5 cycles, updwn=1; result=41; done after E0+6.
- From 250, UP 10 -> result=4 (wrap); then DOWN 5 from 2 -> result=253.
- From 100:
  - GOTO 90 -> updwn=0, 10 steps, result=90.
  - GOTO 90 again -> zero steps, en never high, done after E0+1, result=90.
- From 0, UP 200 with abort pulsed at RUN cycle 20 -> done with aborted=1, result in {20,21}, en low thereafter; cmd_valid held during RUN is not accepted until done.
- Assert rst_n low mid-RUN -> all outputs 0 immediately (async); no done; after release, cmd_ready=1 and the next LOAD completes normally.
